vec_feeder: RTL and testbench

- Double-buffered (ping-pong) vector store that sits on the result side of a dot-product layer.
- Captures a full parallel result vector on the layer's dataReady pulse.
- Serves elements one at a time, indexed by colAddress, as inputVector to the next layer's dot-product engine.
- Provides back-pressure status (vectorValid) and sticky overflow detection when the producer outruns the consumer.

---
 rtl/vec_feeder_if.sv | 40 ++++
 rtl/vec_feeder.sv | 140 ++++++++++++++
 tb/tb_vec_feeder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vec_feeder_if.sv
// rtl/vec_feeder_if.sv - producer/consumer bus bundle for the ping-pong vector store
//
// Purpose: groups the capture strobe, packed result vector, consumer element
// index/release and the read-side outputs of vec_feeder into one bus.
// Ports (signals):
//   dataReady       producer strobe, outputVector valid this cycle
//   outputVector    packed signed vector, element k at [k*BITWIDTH +: BITWIDTH]
//   colAddress      consumer element index
//   consumerRelease consumer finished with the current read bank (1-cycle pulse)
//   inputVector     signed element colAddress of the read bank
//   vectorValid     read bank holds an unconsumed vector
//   overflow        sticky, a vector was dropped with both banks full
// Modports: master = producer/consumer side, slave = vec_feeder.
interface vec_feeder_if #(
  parameter int NROW = 16,
  parameter int QN   = 6,
  parameter int QM   = 11
);
  localparam int BITWIDTH       = QN + QM + 1;
  localparam int ADDR_BITWIDTH  = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int LAYER_BITWIDTH = BITWIDTH * NROW;

  logic                      dataReady;
  logic [LAYER_BITWIDTH-1:0] outputVector;
  logic [ADDR_BITWIDTH-1:0]  colAddress;
  logic                      consumerRelease;
  logic [BITWIDTH-1:0]       inputVector;
  logic                      vectorValid;
  logic                      overflow;

  modport master (
    output dataReady, outputVector, colAddress, consumerRelease,
    input  inputVector, vectorValid, overflow
  );

  modport slave (
    input  dataReady, outputVector, colAddress, consumerRelease,
    output inputVector, vectorValid, overflow
  );
endinterface

// File: rtl/vec_feeder.sv
// rtl/vec_feeder.sv - double-buffered result vector store feeding the next layer element-wise
//
// Purpose: captures a full result vector on dataReady into the free bank of a
// ping-pong pair and serves the read bank one element at a time by colAddress.
// A vector arriving while both banks are occupied is dropped and flags a sticky
// overflow.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    vec_feeder_if.slave (dataReady, outputVector, colAddress,
//          consumerRelease in; inputVector, vectorValid, overflow out)
// Optional feature: define VEC_FEEDER_READ_REG_EN to register inputVector
// (1-cycle read latency); undefined gives a combinational read path.
module vec_feeder #(
  parameter int NROW = 16,
  parameter int QN   = 6,
  parameter int QM   = 11
) (
  input  logic         clk,
  input  logic         reset,
  vec_feeder_if.slave  bus
);
  localparam int BITWIDTH       = QN + QM + 1;
  localparam int ADDR_BITWIDTH  = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int LAYER_BITWIDTH = BITWIDTH * NROW;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic                            rd_sel_q, rd_sel_d;
  logic                            overflow_q, overflow_d;
  logic [1:0][LAYER_BITWIDTH-1:0]  bank_q;
  logic                            wr_en;
  logic                            wr_bank;

  // State register, bank storage and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      rd_sel_q   <= 1'b0;
      overflow_q <= 1'b0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_sel_q   <= rd_sel_d;
      overflow_q <= overflow_d;
      if (wr_en) begin
        bank_q[wr_bank] <= bus.outputVector;
      end
    end
  end

  // Next-state logic. The write target is normally the non-read bank; the one
  // exception is FULL with a simultaneous release, where the old read bank is
  // freed and refilled in the same cycle as rdSel moves off it.
  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_bank    = ~rd_sel_q;

    unique case (state_q)
      S_EMPTY: begin
        if (bus.dataReady) begin
          wr_en    = 1'b1;
          rd_sel_d = ~rd_sel_q;
          state_d  = S_ONE;
        end
      end
      S_ONE: begin
        if (bus.dataReady && bus.consumerRelease) begin
          wr_en    = 1'b1;
          rd_sel_d = ~rd_sel_q;
        end else if (bus.dataReady) begin
          wr_en   = 1'b1;
          state_d = S_FULL;
        end else if (bus.consumerRelease) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (bus.dataReady && bus.consumerRelease) begin
          wr_en    = 1'b1;
          wr_bank  = rd_sel_q;
          rd_sel_d = ~rd_sel_q;
        end else if (bus.dataReady) begin
          overflow_d = 1'b1;
        end else if (bus.consumerRelease) begin
          rd_sel_d = ~rd_sel_q;
          state_d  = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // Read path
  logic                              vector_valid;
  logic                              addr_ok;
  logic [NROW-1:0][BITWIDTH-1:0]     rd_elems;
  logic [BITWIDTH-1:0]               rd_data_d;

  assign vector_valid = (state_q != S_EMPTY);
  assign rd_elems     = bank_q[rd_sel_q];

  // When NROW fills the address space every index is legal.
  if ((1 << ADDR_BITWIDTH) == NROW) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (32'(bus.colAddress) < NROW);
  end

  assign rd_data_d = (vector_valid && addr_ok) ? rd_elems[bus.colAddress] : '0;

`ifdef VEC_FEEDER_READ_REG_EN
  logic [BITWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.inputVector = rd_data_q;
`else
  assign bus.inputVector = rd_data_d;
`endif

  assign bus.vectorValid = vector_valid;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_vec_feeder.sv
// tb/tb_vec_feeder.sv - randomized self-checking bench for vec_feeder against a queue model
module tb_vec_feeder;
  localparam int NROW = 16;
  localparam int QN   = 6;
  localparam int QM   = 11;
  localparam int BW   = QN + QM + 1;
  localparam int LW   = BW * NROW;

  logic clk;
  logic reset;

  vec_feeder_if #(.NROW(NROW), .QN(QN), .QM(QM)) bus ();

  vec_feeder #(.NROW(NROW), .QN(QN), .QM(QM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a FIFO of at most two captured vectors; the head is what
  // the consumer reads. Release pops the head, capture pushes if room remains.
  logic [LW-1:0] m_q[$];
  logic          m_ovf;
  logic [BW-1:0] m_reg;

  function automatic logic [BW-1:0] model_read(input int addr);
    logic [LW-1:0] v;
    if (m_q.size() == 0 || addr >= NROW) return '0;
    v = m_q[0];
    return v[addr*BW +: BW];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_ovf <= 1'b0;
      m_reg <= '0;
    end else begin
      m_reg <= model_read(int'(bus.colAddress));
      if (bus.consumerRelease && m_q.size() > 0) void'(m_q.pop_front());
      if (bus.dataReady) begin
        if (m_q.size() < 2) m_q.push_back(bus.outputVector);
        else m_ovf <= 1'b1;
      end
    end
  end

  function automatic logic [BW-1:0] expected_out(input int addr);
`ifdef VEC_FEEDER_READ_REG_EN
    return m_reg;
`else
    return model_read(addr);
`endif
  endfunction

  function automatic logic [LW-1:0] mk_const(input int val);
    logic [LW-1:0] v;
    for (int k = 0; k < NROW; k++) v[k*BW +: BW] = BW'(val);
    return v;
  endfunction

  function automatic logic [LW-1:0] mk_ramp();
    logic [LW-1:0] v;
    for (int k = 0; k < NROW; k++) v[k*BW +: BW] = BW'(k * 2048);
    return v;
  endfunction

  // One-cycle producer/consumer strobe, held across exactly one rising edge
  task automatic tick(input bit dr, input logic [LW-1:0] vec, input bit cr);
    @(negedge clk);
    bus.dataReady       = dr;
    bus.outputVector    = vec;
    bus.consumerRelease = cr;
    #1;
    check("pre_valid", 32'(bus.vectorValid), 32'(m_q.size() > 0));
    @(posedge clk);
    #1;
    bus.dataReady       = 1'b0;
    bus.consumerRelease = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < NROW; a++) begin
      @(negedge clk);
      bus.colAddress = 4'(a);
      #1;
      check({tag, "_data"}, 32'(bus.inputVector), 32'(expected_out(a)));
    end
    check({tag, "_valid"}, 32'(bus.vectorValid), 32'(m_q.size() > 0));
    check({tag, "_ovf"},   32'(bus.overflow),    32'(m_ovf));
  endtask

  task automatic do_reset(input bit dr);
    @(negedge clk);
    reset          = 1'b1;
    bus.dataReady  = dr;
    bus.outputVector = mk_const(77);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.dataReady = 1'b0;
  endtask

  logic [LW-1:0] v;

  initial begin
    reset               = 1'b1;
    bus.dataReady       = 1'b0;
    bus.outputVector    = '0;
    bus.colAddress      = '0;
    bus.consumerRelease = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and idle
    repeat (5) @(posedge clk);
    sweep("idle");

    // Ramp k.0, then bit-exact negative element
    tick(1'b1, mk_ramp(), 1'b0);
    check("valid_after_dr", 32'(bus.vectorValid), 32'd1);
    sweep("ramp");
    tick(1'b0, '0, 1'b1);
    v = mk_ramp();
    v[3*BW +: BW] = 18'h3F800;
    tick(1'b1, v, 1'b0);
    sweep("neg");
    @(negedge clk);
    bus.colAddress = 4'd3;
    #1;
    check("neg_elem3", 32'(bus.inputVector), 32'h3F800);
    tick(1'b0, '0, 1'b1);

    // Fill both banks, drain in order
    tick(1'b1, mk_const(100), 1'b0);
    tick(1'b1, mk_const(200), 1'b0);
    sweep("full_v1");
    tick(1'b0, '0, 1'b1);
    sweep("rel_v2");
    tick(1'b0, '0, 1'b1);
    sweep("drained");

    // Overflow: third vector dropped, flag sticky
    tick(1'b1, mk_const(100), 1'b0);
    tick(1'b1, mk_const(200), 1'b0);
    tick(1'b1, mk_const(300), 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    sweep("ovf_v1");
    tick(1'b0, '0, 1'b1);
    sweep("ovf_v2");
    tick(1'b0, '0, 1'b1);
    sweep("ovf_empty");

    // Capture plus release while FULL: no overflow
    do_reset(1'b0);
    tick(1'b1, mk_const(100), 1'b0);
    tick(1'b1, mk_const(200), 1'b0);
    tick(1'b1, mk_const(300), 1'b1);
    check("swap_no_ovf", 32'(bus.overflow), 32'd0);
    sweep("swap_v2");
    tick(1'b0, '0, 1'b1);
    sweep("swap_v3");
    tick(1'b0, '0, 1'b1);

    // Reset while FULL, dataReady in the reset cycle ignored
    tick(1'b1, mk_const(100), 1'b0);
    tick(1'b1, mk_const(200), 1'b0);
    tick(1'b1, mk_const(300), 1'b0);
    @(negedge clk);
    bus.colAddress = 4'd5;
    do_reset(1'b1);
    @(negedge clk);
    #1;
    check("rst_valid", 32'(bus.vectorValid), 32'd0);
    check("rst_data",  32'(bus.inputVector), 32'd0);
    check("rst_ovf",   32'(bus.overflow),    32'd0);
    tick(1'b1, mk_ramp(), 1'b0);
    sweep("post_rst");
    tick(1'b0, '0, 1'b1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset               = ($urandom_range(0, 99) == 0);
      bus.dataReady       = ($urandom_range(0, 2) == 0);
      bus.consumerRelease = ($urandom_range(0, 2) == 0);
      bus.colAddress      = 4'($urandom_range(0, NROW - 1));
      for (int k = 0; k < NROW; k++) v[k*BW +: BW] = BW'($urandom);
      bus.outputVector    = v;
      #1;
      check("rnd_data",  32'(bus.inputVector), 32'(expected_out(int'(bus.colAddress))));
      check("rnd_valid", 32'(bus.vectorValid), 32'(m_q.size() > 0));
      check("rnd_ovf",   32'(bus.overflow),    32'(m_ovf));
    end
    @(negedge clk);
    reset               = 1'b0;
    bus.dataReady       = 1'b0;
    bus.consumerRelease = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
